sim_status_monitor: RTL
=======================

# sim_status_monitor

Synthesizable, parametrised simulation-control monitor for the SoC test harness. It watches N core write-back channels for pass/fail magic values and runs a cycle-budget timeout. It also passively snoops the AXI write channels, extracts console characters written to a fixed address, and buffers them in a FIFO for a host or bench to drain. It sits beside the CPU subsystem and the AXI slave, and never drives the bus.

## Interface
Parameters:
- `WB_CH`, 2: number of 64-bit write-back channels monitored.
- `DATA_W`, 128: AXI write-data width; a multiple of 32, at most 512.
- `ADDR_W`, 32: AXI address width.
- `CONSOLE_ADDR`, 32'h01ff_fff0: console character address.
- `PASS_VAL`, 64'h0000_0004_4433_3222: pass magic value.
- `FAIL_VAL`, 64'h0000_0023_8234_8720: fail magic value.
- `MAX_CYCLES`, 32'h0300_0000: timeout budget; 0 disables the timeout.
- `FIFO_DEPTH`, 16: character FIFO depth; a power of two, at least 2.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `wb_vld` in `WB_CH`: per-channel write-back valid.
- `wb_data` in 64*`WB_CH`: channel k occupies bits [64k+63:64k].
- `aw_valid`, `aw_ready` in 1 each: AXI AW handshake.
- `aw_addr` in `ADDR_W`: write address.
- `aw_len` in 8: burst length minus 1.
- `w_valid`, `w_ready`, `w_last` in 1 each: AXI W handshake and last beat.
- `w_data` in `DATA_W`: write data.
- `w_strb` in `DATA_W`/8: byte strobes.
- `char_vld` out 1: head of the FIFO is valid.
- `char_data` out 8: FIFO head byte.
- `char_rdy` in 1: pop request.
- `done`, `pass`, `fail`, `timeout` out 1 each: sticky status flags.
- `cycle_cnt` out 32: cycles elapsed in RUN.
- `drop_cnt` out 8: characters lost to a full FIFO; saturates at 8'hff.
- `aw_ovf` out 1: sticky flag for AW-tag queue overflow.

## Operation
- Status FSM states:
  - RUN: the reset state.
  - PASS, FAIL, TOUT: terminal states, left only by `rst`.
- Transitions out of RUN, evaluated once per cycle in priority order:
  - FAIL if any channel k has `wb_vld[k]` set and `wb_data` == `FAIL_VAL`.
  - Else PASS if any channel matches `PASS_VAL` under the same condition.
  - Else TOUT if `MAX_CYCLES` != 0 and `cycle_cnt` == `MAX_CYCLES`-1.
- Matches with `wb_vld`=0 are ignored. Channels are ORed together; their index does not matter.
- Status outputs:
  - `done` = state != RUN.
  - `pass`, `fail`, `timeout` each decode their own terminal state.
- `cycle_cnt` increments by 1 on every RUN cycle and freezes on the transition out of RUN.
- AW-tag queue: a 4-entry FIFO of {console, len}.
  - Push on an AW handshake.
  - console = (`aw_len`==0) and (`aw_addr`==`CONSOLE_ADDR`).
  - On a push to a full queue, the entry is discarded and `aw_ovf` is set.
- W tracking:
  - Each W handshake is attributed to the queue head.
  - Pop on the W handshake that has `w_last`=1.
  - A W handshake while the queue is empty is ignored. This includes the case where AW and W handshake in the same cycle with the queue empty; a same-cycle AW uses bypass, so its W beat is attributed correctly.
- Character extraction applies on a W beat whose head entry has console=1:
  - If `w_strb` equals exactly 4'hf << 4j for some lane j < `DATA_W`/32, the character is `w_data`[32j+7:32j].
  - Any other strobe pattern produces no character.
- Character FIFO:
  - Push the extracted byte.
  - Pop when `char_vld` and `char_rdy` are both 1.
  - A push when full and not popping is dropped and increments `drop_cnt`.
  - Simultaneous push and pop when full: both take effect, and the count stays full.
- Capture continues after `done`, so that trailing messages drain.

## Timing
- Reset values:
  - State = RUN.
  - `done`, `pass`, `fail`, `timeout` = 0.
  - `cycle_cnt` = 0, `drop_cnt` = 0, `aw_ovf` = 0.
  - `char_vld` = 0, `char_data` = 0.
  - Both FIFOs empty.
- `rst` asserted mid-operation clears everything asynchronously, including buffered characters.
- Status flags assert on the clock edge after the matching `wb` cycle (1-cycle latency).
- Timeout: `timeout` rises on the edge at which `cycle_cnt` would reach `MAX_CYCLES`. `cycle_cnt` then reads `MAX_CYCLES`-1 or more and stays frozen.
- Character path:
  - A W handshake at edge n makes `char_vld` 1 with the correct `char_data` after edge n+1.
  - `char_data` is registered; `char_vld` has no combinational path from `w_*`.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2*`FIFO_DEPTH`.
  - full = pointer MSBs differ and lower bits are equal.
  - empty = pointers are equal.

## Test plan
- Channel 1 shows `wb_vld`=1 with 64'h444333222 at cycle 50 -> `pass`=`done`=1 at cycle 51, `cycle_cnt` frozen at 51, `fail`=0.
- Channel 0 shows FAIL_VAL and channel 1 shows PASS_VAL in the same cycle -> `fail`=1, `pass`=0. A matching value with `wb_vld`=0 -> no change.
- `MAX_CYCLES`=100 with no magic values -> `timeout`=1 after the 100th edge, `cycle_cnt`=99. A later PASS_VAL is ignored.
- `DATA_W`=128: AW to 0x01ff_fff0 with len 0, then W with `w_strb`=16'h0f00 and `w_data`[71:64]=8'h41 -> `char_vld`=1 with `char_data`=8'h41 two edges after the W handshake. `w_strb`=16'h0ff0 -> no character.
- Two AWs (non-console len 3, then console) followed by 4+1 W beats -> exactly one character, from the 5th beat. A 5th outstanding AW -> `aw_ovf`=1.
- `FIFO_DEPTH`=4, `char_rdy`=0, 6 console writes -> 4 characters retained in order, `drop_cnt`=2. Then pop with simultaneous push while full -> order preserved. Assert `rst` -> all outputs return to reset values.

Source files
------------

// File: rtl/sim_status_monitor.sv
// Simulation-control monitor: pass/fail/timeout status from core write-back channels,
// plus passive AXI console-character capture into a drainable FIFO.
module sim_status_monitor #(
  parameter int                WB_CH        = 2,
  parameter int                DATA_W       = 128,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h01ff_fff0,
  parameter logic [63:0]       PASS_VAL     = 64'h0000_0004_4433_3222,
  parameter logic [63:0]       FAIL_VAL     = 64'h0000_0023_8234_8720,
  parameter logic [31:0]       MAX_CYCLES   = 32'h0300_0000,
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_CH-1:0]      wb_vld,
  input  logic [64*WB_CH-1:0]   wb_data,
  input  logic                  aw_valid,
  input  logic                  aw_ready,
  input  logic [ADDR_W-1:0]     aw_addr,
  input  logic [7:0]            aw_len,
  input  logic                  w_valid,
  input  logic                  w_ready,
  input  logic                  w_last,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_strb,
  output logic                  char_vld,
  output logic [7:0]            char_data,
  input  logic                  char_rdy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [31:0]           cycle_cnt,
  output logic [7:0]            drop_cnt,
  output logic                  aw_ovf
);
  localparam int SW    = DATA_W / 8;
  localparam int LANES = DATA_W / 32;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] LANE0_STRB = SW'(4'hf);

  // Handshakes: a beat transfers on a cycle where valid and ready are both 1.
  logic aw_hs, w_hs;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  // ---------------- status FSM ----------------
  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;
  state_t state, state_nxt;
  logic   fail_hit, pass_hit, tout_hit;

  always_comb begin
    fail_hit = 1'b0;
    pass_hit = 1'b0;
    for (int k = 0; k < WB_CH; k++) begin
      if (wb_vld[k] && (wb_data[64*k +: 64] == FAIL_VAL)) fail_hit = 1'b1;
      if (wb_vld[k] && (wb_data[64*k +: 64] == PASS_VAL)) pass_hit = 1'b1;
    end
    tout_hit  = (MAX_CYCLES != 32'd0) && (cycle_cnt == MAX_CYCLES - 32'd1);
    state_nxt = state;
    if (state == S_RUN) begin
      if (fail_hit)      state_nxt = S_FAIL;
      else if (pass_hit) state_nxt = S_PASS;
      else if (tout_hit) state_nxt = S_TOUT;
    end
  end

  // The counter counts the exiting cycle on pass/fail, but holds at MAX_CYCLES-1 on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN && state_nxt != S_TOUT) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign done    = (state != S_RUN);
  assign pass    = (state == S_PASS);
  assign fail    = (state == S_FAIL);
  assign timeout = (state == S_TOUT);

  // ---------------- AW-tag queue (console bit per outstanding burst) ----------------
  logic       aq_mem [4];
  logic [2:0] aq_wr, aq_rd;
  logic       aq_empty, aq_full, aw_con, head_vld, head_con, aq_push, aq_pop;

  assign aw_con   = (aw_len == 8'd0) && (aw_addr == CONSOLE_ADDR);
  assign aq_empty = (aq_wr == aq_rd);
  assign aq_full  = (aq_wr[2] != aq_rd[2]) && (aq_wr[1:0] == aq_rd[1:0]);
  // Bypass lets a W beat in the same cycle as its AW see the new tag.
  assign head_vld = !aq_empty || aw_hs;
  assign head_con = aq_empty ? aw_con : aq_mem[aq_rd[1:0]];
  assign aq_push  = aw_hs && !aq_full;
  assign aq_pop   = w_hs && w_last && head_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wr  <= '0;
      aq_rd  <= '0;
      aw_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) aq_mem[i] <= 1'b0;
    end else begin
      if (aq_push) begin
        aq_mem[aq_wr[1:0]] <= aw_con;
        aq_wr              <= aq_wr + 3'd1;
      end
      if (aq_pop) aq_rd <= aq_rd + 3'd1;
      if (aw_hs && aq_full) aw_ovf <= 1'b1;
    end
  end

  // ---------------- character extraction ----------------
  logic       lane_hit, ext_vld;
  logic [7:0] lane_byte, ext_byte;
  logic       unused_bits;
  assign unused_bits = ^w_data;

  always_comb begin
    lane_hit  = 1'b0;
    lane_byte = 8'd0;
    for (int j = 0; j < LANES; j++) begin
      if (w_strb == (LANE0_STRB << (4*j))) begin
        lane_hit  = 1'b1;
        lane_byte = w_data[32*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_vld  <= 1'b0;
      ext_byte <= 8'd0;
    end else begin
      ext_vld  <= w_hs && head_vld && head_con && lane_hit;
      ext_byte <= lane_byte;
    end
  end

  // ---------------- character FIFO ----------------
  logic [7:0]  cf_mem [FIFO_DEPTH];
  logic [PW:0] cf_wr, cf_rd;
  logic        cf_full, cf_pop, cf_push;

  assign cf_full   = (cf_wr[PW] != cf_rd[PW]) && (cf_wr[PW-1:0] == cf_rd[PW-1:0]);
  assign char_vld  = (cf_wr != cf_rd);
  assign char_data = cf_mem[cf_rd[PW-1:0]];
  assign cf_pop    = char_vld && char_rdy;
  assign cf_push   = ext_vld && (!cf_full || cf_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf_wr    <= '0;
      cf_rd    <= '0;
      drop_cnt <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) cf_mem[i] <= 8'd0;
    end else begin
      if (cf_push) begin
        cf_mem[cf_wr[PW-1:0]] <= ext_byte;
        cf_wr                 <= cf_wr + 1'b1;
      end
      if (cf_pop) cf_rd <= cf_rd + 1'b1;
      if (ext_vld && cf_full && !cf_pop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule
